// File: rtl/mfa_pkg.sv
// mfa_pkg: shared defaults, state encoding and saturating-add helper
// for the MFA box-counting pipeline.
package mfa_pkg;

  localparam int DEF_BOX_IDX  = 3;
  localparam int DEF_IMG_IDX  = 5;
  localparam int DEF_DATA_LEN = 12;

  localparam logic FINE_REGION = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DONE
  } fill_state_e;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic        b,
    input int          w
  );
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    return (b && (a < mx)) ? a + 32'd1 : a;
  endfunction

endpackage

// File: rtl/box_acc_bank.sv
// box_acc_bank: one saturating accumulator per finest box column,
// with an increment port and a read-and-clear port.
module box_acc_bank
  import mfa_pkg::*;
#(
  parameter int BOX_IDX  = DEF_BOX_IDX,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_inc_en,
  input  logic [BOX_IDX-1:0]  i_inc_idx,
  input  logic                i_inc_pix,
  input  logic                i_rd_en,
  input  logic [BOX_IDX-1:0]  i_rd_idx,
  output logic [DATA_LEN-1:0] o_rd_data
);

  localparam int NB = 1 << BOX_IDX;

  logic [DATA_LEN-1:0] r_acc [NB];
  logic [DATA_LEN-1:0] w_inc_val;

  assign w_inc_val = DATA_LEN'(sat_add(
    32'(r_acc[i_inc_idx]), i_inc_pix, DATA_LEN));

  // a read in the same cycle as an increment sees the new count
  assign o_rd_data =
    (i_inc_en && (i_inc_idx == i_rd_idx)) ?
    w_inc_val : r_acc[i_rd_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NB; k++) r_acc[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < NB; k++) r_acc[k] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (i_rd_en && (i_rd_idx == BOX_IDX'(k)))
          r_acc[k] <= '0;
        else if (i_inc_en && (i_inc_idx == BOX_IDX'(k)))
          r_acc[k] <= w_inc_val;
      end
    end
  end

endmodule

// File: rtl/box_fill.sv
// box_fill: counts set pixels per finest box and writes them to the
// box-count RAM. Optional occupied-box counter: BOX_FILL_OCC_CNT_EN.
module box_fill
  import mfa_pkg::*;
#(
  parameter int BOX_IDX  = DEF_BOX_IDX,
  parameter int IMG_IDX  = DEF_IMG_IDX,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                pix,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic                BC_mode,
  output logic                wen_bc,
  output logic [2*BOX_IDX:0]  BC_wr_addr,
  output logic [DATA_LEN-1:0] bc_data,
  output logic                done
`ifdef BOX_FILL_OCC_CNT_EN
  ,
  output logic [2*BOX_IDX:0]  occ_cnt
`endif
);

  localparam int SB = IMG_IDX - BOX_IDX;

  fill_state_e r_state, w_next;

  logic [IMG_IDX-1:0]  r_col, r_row;
  logic [BOX_IDX-1:0]  r_by, r_fi;
  logic                r_wen, r_bc_mode;
  logic [2*BOX_IDX:0]  r_addr;
  logic [DATA_LEN-1:0] r_data;

  logic                w_start, w_accept;
  logic                w_row_end, w_eobr;
  logic                w_fl_last, w_rd_en;
  logic [BOX_IDX-1:0]  w_bx, w_row_by;
  logic [BOX_IDX-1:0]  w_rd_idx, w_by_src;
  logic [DATA_LEN-1:0] w_rd_data;

  assign w_bx     = r_col[IMG_IDX-1 -: BOX_IDX];
  assign w_row_by = r_row[IMG_IDX-1 -: BOX_IDX];

  generate
    if (SB == 0) begin : g_s1
      assign w_row_end = 1'b1;
    end else begin : g_sn
      assign w_row_end = &r_row[SB-1:0];
    end
  endgenerate

  assign w_start   = (r_state == IDLE) && start;
  assign w_accept  = (r_state == ACCUM) && pix_valid;
  assign w_eobr    = w_accept && (&r_col) && w_row_end;
  assign w_fl_last = (r_state == FLUSH) && (&r_fi);

  // the read for box i is issued one edge early so the
  // registered write lines up with flush cycle i
  assign w_rd_en  = w_eobr ||
                    ((r_state == FLUSH) && !(&r_fi));
  assign w_rd_idx = w_eobr ? '0 : r_fi + 1'b1;
  assign w_by_src = w_eobr ? w_row_by : r_by;

  assign pix_ready  = (r_state == ACCUM);
  assign done       = (r_state == DONE);
  assign BC_mode    = r_bc_mode;
  assign wen_bc     = r_wen;
  assign BC_wr_addr = r_addr;
  assign bc_data    = r_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = ACCUM;
      ACCUM: if (w_eobr) w_next = FLUSH;
      FLUSH: if (w_fl_last)
               w_next = (&r_by) ? DONE : ACCUM;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_col     <= '0;
      r_row     <= '0;
      r_by      <= '0;
      r_fi      <= '0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_bc_mode <= 1'b1;
    end else begin
      r_wen <= w_rd_en;
      if (w_rd_en) begin
        r_addr <= {w_rd_idx, FINE_REGION, w_by_src};
        r_data <= w_rd_data;
      end
      if (w_start) begin
        r_col     <= '0;
        r_row     <= '0;
        r_bc_mode <= 1'b1;
      end else if (w_accept) begin
        r_col <= r_col + 1'b1;
        if (&r_col) r_row <= r_row + 1'b1;
      end
      if (w_eobr) begin
        r_by <= w_row_by;
        r_fi <= '0;
      end else if (r_state == FLUSH) begin
        r_fi <= r_fi + 1'b1;
      end
      if (r_state == DONE) r_bc_mode <= 1'b0;
    end
  end

  box_acc_bank #(
    .BOX_IDX  (BOX_IDX),
    .DATA_LEN (DATA_LEN)
  ) u_bank (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_clr     (w_start),
    .i_inc_en  (w_accept),
    .i_inc_idx (w_bx),
    .i_inc_pix (pix),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

`ifdef BOX_FILL_OCC_CNT_EN
  logic [2*BOX_IDX:0] r_occ;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_occ <= '0;
    else if (w_start)
      r_occ <= '0;
    else if (r_wen && (r_data != '0))
      r_occ <= r_occ + 1'b1;
  end

  assign occ_cnt = r_occ;
`endif

endmodule

// File: tb/tb_box_fill.sv
// tb_box_fill: directed frames against box_fill (default and
// DATA_LEN=4 instances driven in lockstep).
module tb_box_fill;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        pix = 1'b0;
  logic        pix_valid = 1'b0;

  logic        pix_ready, BC_mode, wen_bc, done;
  logic [6:0]  BC_wr_addr;
  logic [11:0] bc_data;
  logic        rdy4, bcm4, wen4, done4;
  logic [6:0]  addr4;
  logic [3:0]  data4;
`ifdef BOX_FILL_OCC_CNT_EN
  logic [6:0]  occ_cnt, occ4;
`endif

  always #5 CLK = ~CLK;

  box_fill dut (
    .CLK(CLK), .RST(RST), .start(start), .pix(pix),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .BC_mode(BC_mode), .wen_bc(wen_bc),
    .BC_wr_addr(BC_wr_addr), .bc_data(bc_data),
    .done(done)
`ifdef BOX_FILL_OCC_CNT_EN
    , .occ_cnt(occ_cnt)
`endif
  );

  box_fill #(.DATA_LEN(4)) dut4 (
    .CLK(CLK), .RST(RST), .start(start), .pix(pix),
    .pix_valid(pix_valid), .pix_ready(rdy4),
    .BC_mode(bcm4), .wen_bc(wen4),
    .BC_wr_addr(addr4), .bc_data(data4),
    .done(done4)
`ifdef BOX_FILL_OCC_CNT_EN
    , .occ_cnt(occ4)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [6:0]  wa_q[$];
  logic [11:0] wd_q[$];
  logic [3:0]  wd4_q[$];

  bit frame_on = 0;
  int cyc = 0, nacc = 0, low_run = 0;
  int last_len = 0, done_cnt = 0;
  int gap_runs = 0, gap_err = 0, bcm_err = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      frame_on = 0;
      low_run  = 0;
    end else begin
      if (wen_bc) begin
        wa_q.push_back(BC_wr_addr);
        wd_q.push_back(bc_data);
      end
      if (wen4) wd4_q.push_back(data4);
      if (done) done_cnt++;
      if (pix_valid && pix_ready && !frame_on) begin
        frame_on = 1;
        cyc = 0;
        nacc = 0;
      end
      if (frame_on) begin
        cyc++;
        if (!BC_mode) bcm_err++;
        if (done) begin
          last_len = cyc;
          frame_on = 0;
          low_run  = 0;
        end else if (!pix_ready) begin
          if (low_run == 0 && (nacc == 0 || nacc % 128 != 0))
            gap_err++;
          low_run++;
        end else begin
          if (low_run != 0) begin
            gap_runs++;
            if (low_run != 8) gap_err++;
          end
          low_run = 0;
        end
        if (pix_valid && pix_ready) nacc++;
      end
    end
  end

  function automatic logic img(input int mode, input int c,
                               input int r);
    return (mode == 0) ? 1'b1 : (c == 5 && r == 9);
  endfunction

  task automatic kick();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic drive(input int mode, input bit gaps,
                       input int npix);
    int c = 0, r = 0, n = 0, g = 0;
    bit a;
    while (n < npix && g < 40000) begin
      pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix = img(mode, c, r);
      @(negedge CLK);
      a = pix_valid && pix_ready;
      @(posedge CLK); #1;
      g++;
      if (a) begin
        n++;
        c++;
        if (c == 32) begin c = 0; r++; end
      end
    end
    pix_valid = 1'b0;
    pix = 1'b0;
    chk("drive_n", n, npix);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++)
      @(negedge CLK);
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    wd4_q.delete();
  endtask

  task automatic check_frame(input int mode);
    logic [31:0] ea, ed, e4;
    chk("nwr", wa_q.size(), 64);
    chk("nwr4", wd4_q.size(), 64);
    for (int k = 0; k < 64; k++) begin
      ea = ((k % 8) << 4) | (k / 8);
      ed = (mode == 0) ? 16 : ((k == 17) ? 1 : 0);
      e4 = (mode == 0) ? 15 : ((k == 17) ? 1 : 0);
      if (k < wa_q.size()) begin
        chk($sformatf("addr[%0d]", k), wa_q[k], ea);
        chk($sformatf("data[%0d]", k), wd_q[k], ed);
      end
      if (k < wd4_q.size())
        chk($sformatf("sat4[%0d]", k), wd4_q[k], e4);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int d0, g0, e0, b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_bcm", BC_mode, 1);
    chk("rst_rdy", pix_ready, 0);
    chk("rst_wen", wen_bc, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", BC_wr_addr, 0);
    chk("rst_data", bc_data, 0);
`ifdef BOX_FILL_OCC_CNT_EN
    chk("rst_occ", occ_cnt, 0);
`endif
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // all-ones frame, continuous valid
    clear_q();
    d0 = done_cnt; g0 = gap_runs; e0 = gap_err; b0 = bcm_err;
    kick();
    drive(0, 0, 1024);
    wait_done(d0);
    check_frame(0);
    chk("len1", last_len, 1089);
    chk("gapn1", gap_runs - g0, 7);
    chk("gaperr1", gap_err - e0, 0);
    chk("bcm_fill1", bcm_err - b0, 0);
    repeat (3) @(negedge CLK);
    chk("done_once1", done_cnt - d0, 1);
    chk("bcm_idle1", BC_mode, 0);
`ifdef BOX_FILL_OCC_CNT_EN
    chk("occ1", occ_cnt, 64);
`endif
    @(posedge CLK); #1;

    // single pixel, start pulsed during ACCUM and DONE
    clear_q();
    d0 = done_cnt;
    kick();
    fork
      drive(1, 0, 1024);
      begin
        repeat (300) @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        for (int i = 0; i < 3000 && !done; i++)
          @(negedge CLK);
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
      end
    join
    wait_done(d0);
    check_frame(1);
    chk("len2", last_len, 1089);
    repeat (3) @(negedge CLK);
    chk("done_once2", done_cnt - d0, 1);
    chk("idle_rdy2", pix_ready, 0);
    chk("idle_bcm2", BC_mode, 0);
`ifdef BOX_FILL_OCC_CNT_EN
    chk("occ2", occ_cnt, 1);
`endif
    @(posedge CLK); #1;

    // all-ones frame with random valid gaps
    clear_q();
    d0 = done_cnt; g0 = gap_runs; e0 = gap_err;
    kick();
    drive(0, 1, 1024);
    wait_done(d0);
    check_frame(0);
    chk("gapn3", gap_runs - g0, 7);
    chk("gaperr3", gap_err - e0, 0);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;

    // reset during the flush of box row 3
    clear_q();
    kick();
    drive(0, 0, 512);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("midflush", wen_bc, 1);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("mr_bcm", BC_mode, 1);
    chk("mr_rdy", pix_ready, 0);
    chk("mr_wen", wen_bc, 0);
    chk("mr_done", done, 0);
    chk("mr_addr", BC_wr_addr, 0);
    chk("mr_data", bc_data, 0);
    clear_q();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("mr_nowr", wa_q.size(), 0);
    chk("mr_bcm2", BC_mode, 1);

    // fresh frame after the reset
    clear_q();
    d0 = done_cnt;
    kick();
    drive(0, 0, 1024);
    wait_done(d0);
    check_frame(0);
    chk("len5", last_len, 1089);
`ifdef BOX_FILL_OCC_CNT_EN
    chk("occ5", occ_cnt, 64);
`endif
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/box_fill.md
Name: box_fill

Overview:
- Upstream feeder of the square-grouping (quad-sum) stage in the MFA box-counting pipeline.
- Accepts a raster-order binary image stream and counts set pixels per finest box.
- Writes one count per box into the box-count RAM's finest-level region (address bit BOX_IDX = 0).
- Holds the quad-sum stage idle via BC_mode while filling; releases it when the fill is complete.

Parameters:
- BOX_IDX, 3: log2 of boxes per side at the finest level; the RAM address is 2*BOX_IDX+1 bits.
- IMG_IDX, 5: log2 of image side in pixels; must satisfy IMG_IDX >= BOX_IDX; box side S = 2^(IMG_IDX-BOX_IDX).
- DATA_LEN, 12: count width; must match the quad-sum stage.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame fill; ignored unless IDLE.
- pix  in  1  pixel value; 1 = set.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- BC_mode  out  1  high = fill in progress; holds the quad-sum stage in its reset state.
- wen_bc  out  1  RAM write enable.
- BC_wr_addr  out  2*BOX_IDX+1  write address: {box_x, 1'b0, box_y}.
- bc_data  out  DATA_LEN  write data.
- done  out  1  one-cycle pulse when the last box count has been written.
- occ_cnt  out  2*BOX_IDX+1  occupied-box count; present only with the macro.

Behaviour:
- Reset values (RST = 0): state IDLE, BC_mode = 1, pix_ready = 0, wen_bc = 0, done = 0, BC_wr_addr = 0, bc_data = 0. All counters and accumulators are 0.
- State IDLE -> ACCUM on start.
  - Clear the pixel column/row counters (IMG_IDX bits each) and all accumulators.
  - Hold BC_mode = 1.
- State ACCUM: pix_ready = 1.
  - On each accepted pixel, acc[bx] <= sat(acc[bx] + pix), where bx = col[IMG_IDX-1:IMG_IDX-BOX_IDX].
  - sat clamps at 2^DATA_LEN-1 and never wraps.
  - col increments; at col = 2^IMG_IDX-1 it wraps to 0 and row increments.
  - When the accepted pixel has col all-ones and row[IMG_IDX-BOX_IDX-1:0] all-ones (the end of a box row): go to FLUSH, latching by = row[IMG_IDX-1:IMG_IDX-BOX_IDX].
  - With S = 1 (IMG_IDX = BOX_IDX), every line ends a box row.
- State FLUSH: pix_ready = 0.
  - Lasts 2^BOX_IDX cycles, i = 0 .. 2^BOX_IDX-1.
  - Each cycle: wen_bc = 1, BC_wr_addr = {i, 1'b0, by}, bc_data = acc[i]; acc[i] cleared the same cycle.
  - After i = max: if by = 2^BOX_IDX-1, go to DONE; else go to ACCUM.
  - Address, data and write enable are driven from registers and change together.
- State DONE: done = 1 for one cycle, BC_mode <= 0, then go to IDLE.
  - BC_mode stays 0 in IDLE until the next accepted start.
- Latency and throughput:
  - Frame time = 4^IMG_IDX accepted pixels + 4^BOX_IDX flush cycles + 1 (DONE).
  - Pixel gaps (pix_valid = 0) stall counters only.
- Boundaries:
  - start during ACCUM/FLUSH/DONE: ignored.
  - pix_valid outside ACCUM: not accepted; no state change.
  - start and DONE in the same cycle: start ignored.
  - Reset mid-frame: immediate return to reset values; no partial writes afterwards.
- Arithmetic: counts never exceed S^2 unless DATA_LEN is undersized; saturation covers that case.

Optional Feature:
- Macro BOX_FILL_OCC_CNT_EN.
- Defined:
  - occ_cnt port exists.
  - Cleared on start; increments on every FLUSH write whose bc_data != 0.
  - Holds its value after done until the next start. This gives N(eps) at the finest scale.
- Undefined: port, counter and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mfa_pkg:
  - BOX_IDX, IMG_IDX, DATA_LEN defaults.
  - Address-region constant FINE_REGION = 1'b0 (bit BOX_IDX).
  - State enum {IDLE, ACCUM, FLUSH, DONE}.
  - Saturating-add function.
- One natural sub-module: box_acc_bank. It holds 2^BOX_IDX accumulators with increment port (bx, pix, en) and read-clear port (i, en). The FSM and address generation stay in box_fill.

Test Plan:
- All-ones 32x32 frame (defaults) -> 64 writes, each bc_data = 16.
  - Addresses cover {x,0,y} for x,y in 0..7, in order y-major, x-minor.
  - done exactly 1024+64+1 cycles after the first accept with continuous valid.
- Single set pixel at col 5, row 9 -> write to BC_wr_addr = 7'h12 with bc_data = 1; the other 63 writes are 0; occ_cnt = 1 with macro.
- Random pix_valid gaps (50%) -> same counts as the gap-free run.
  - pix_ready = 0 for exactly 8 cycles after every 128th accepted pixel.
  - No pixel lost or duplicated.
- Reset asserted mid-flush of box row 3 -> all outputs at reset values on the next edge; BC_mode = 1.
  - A fresh start then produces a full correct frame.
- start pulsed during ACCUM and during DONE -> ignored; frame count and done timing are unchanged.
- DATA_LEN = 4 override with an all-ones frame -> every bc_data = 15 (saturated, no wrap).
